// File: rtl/and3_pkg.sv
// Shared definitions for the 3-input AND gate exerciser.
package and3_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the per-vector settle counter; SETTLE must fit in it (0..15).
  localparam int SETTLE_W = 4;

  // Reference AND over the bits selected by mask: 1 only when every
  // selected bit of vec is set.
  function automatic logic expected_and(input logic [31:0] vec,
                                        input logic [31:0] mask);
    return (vec & mask) == mask;
  endfunction

endpackage

// File: rtl/and3_exerciser.sv
// Stimulus/response engine that sweeps every input combination into an
// N_IN-input AND gate, samples its output and scores the result.
module and3_exerciser
  import and3_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  output logic [N_IN-1:0] o_e,
  input  logic            i_s,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_pass,
  output logic [N_IN:0]   o_err_count,
  output logic            o_fail_valid,
  output logic [N_IN-1:0] o_fail_vec
);

  localparam logic [N_IN-1:0]     LAST_VEC   = '1;
  localparam logic [SETTLE_W-1:0] SETTLE_CNT = SETTLE_W'(SETTLE);

  state_e                r_state;
  logic [N_IN-1:0]       r_vec;
  logic [SETTLE_W-1:0]   r_cnt;
  logic [N_IN:0]         r_errCount;
  logic                  r_failValid;
  logic [N_IN-1:0]       r_failVec;

  logic                  w_sampleEdge;
  logic                  w_mismatch;
  logic                  w_startOk;

  assign w_startOk    = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_sampleEdge = (r_state == ST_RUN) && (r_cnt == SETTLE_CNT);
  assign w_mismatch   = w_sampleEdge &&
                        (i_s != expected_and(32'(r_vec), 32'(LAST_VEC)));

  // Sequencer, settle counter and scoreboard; start from IDLE or DONE clears
  // the previous result, start during a sweep is ignored.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_vec       <= '0;
      r_cnt       <= '0;
      r_errCount  <= '0;
      r_failValid <= 1'b0;
      r_failVec   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_startOk) begin
            r_state     <= ST_RUN;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_errCount  <= '0;
            r_failValid <= 1'b0;
            r_failVec   <= '0;
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_sampleEdge) begin
            if (w_mismatch) begin
              r_errCount <= r_errCount + 1'b1;
              if (!r_failValid) begin
                r_failValid <= 1'b1;
                r_failVec   <= r_vec;
              end
            end
            if (r_vec != LAST_VEC) begin
              r_vec <= r_vec + 1'b1;
              r_cnt <= '0;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = (r_state == ST_RUN);
  assign o_done       = (r_state == ST_DONE);
  assign o_e          = o_busy ? r_vec : '0;
  assign o_pass       = o_done && (r_errCount == '0);
  assign o_err_count  = r_errCount;
  assign o_fail_valid = r_failValid;
  assign o_fail_vec   = r_failVec;

endmodule

// File: tb/tb_and3_exerciser.sv
// Bench for and3_exerciser: a default build driven through a lookup table
// standing in for the gate, and a SETTLE=3 build with glitching s.
module tb_and3_exerciser;

  typedef struct {
    logic [7:0] sTable;
    logic [3:0] expErr;
    logic       expFailValid;
    logic [2:0] expFailVec;
    logic       expPass;
  } vecRec_t;

  logic       clk = 1'b0;
  logic       rstN;
  logic       start1, start2;
  logic [7:0] sTable;
  logic       s1, s2;
  logic [2:0] e1, e2;
  logic       busy1, done1, pass1, fv1;
  logic       busy2, done2, pass2, fv2;
  logic [3:0] err1, err2;
  logic [2:0] fvec1, fvec2;

  int nApplied = 0;
  int nMiscomp = 0;
  vecRec_t vecs[$];

  always #5 clk = ~clk;

  assign s1 = sTable[e1];

  and3_exerciser #(.N_IN(3), .SETTLE(1)) dut1 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start1), .o_e(e1), .i_s(s1),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_err_count(err1),
    .o_fail_valid(fv1), .o_fail_vec(fvec1)
  );

  and3_exerciser #(.N_IN(3), .SETTLE(3)) dut2 (
    .i_clk(clk), .i_rst_n(rstN), .i_start(start2), .o_e(e2), .i_s(s2),
    .o_busy(busy2), .o_done(done2), .o_pass(pass2), .o_err_count(err2),
    .o_fail_valid(fv2), .o_fail_vec(fvec2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nApplied++;
    if (actual !== expected) begin
      nMiscomp++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: the gate output for vector v is 1 only for v==7; count every
  // vector where the observed s differs and remember the lowest one.
  function automatic vecRec_t modelSweep(input logic [7:0] tbl);
    vecRec_t r;
    r.sTable       = tbl;
    r.expErr       = 0;
    r.expFailValid = 0;
    r.expFailVec   = 0;
    for (int v = 0; v < 8; v++) begin
      if (tbl[v] != (v == 7)) begin
        if (!r.expFailValid) begin
          r.expFailValid = 1;
          r.expFailVec   = 3'(v);
        end
        r.expErr = r.expErr + 1;
      end
    end
    r.expPass = (r.expErr == 0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vecRec_t r, input string tag);
    sTable = r.sTable;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 16; j++) begin
      checkOutput({tag, ".e"}, 32'(e1), 32'(j / 2));
      if (j == 0 || j == 15) begin
        checkOutput({tag, ".busy"}, 32'(busy1), 1);
        checkOutput({tag, ".doneEarly"}, 32'(done1), 0);
      end
      tick();
    end
    checkOutput({tag, ".done"}, 32'(done1), 1);
    checkOutput({tag, ".busyEnd"}, 32'(busy1), 0);
    checkOutput({tag, ".eIdle"}, 32'(e1), 0);
    checkOutput({tag, ".err"}, 32'(err1), 32'(r.expErr));
    checkOutput({tag, ".failValid"}, 32'(fv1), 32'(r.expFailValid));
    if (r.expFailValid)
      checkOutput({tag, ".failVec"}, 32'(fvec1), 32'(r.expFailVec));
    checkOutput({tag, ".pass"}, 32'(pass1), 32'(r.expPass));
  endtask

  // SETTLE=3 sweep: s is the wrong value in the three non-sample cycles of
  // every vector; in the sample cycle it is correct except for badVec.
  task automatic sweepSettle3(input int badVec, input string tag);
    int  v;
    logic good;
    start2 = 1'b1;
    tick();
    for (int j = 0; j < 32; j++) begin
      v    = j / 4;
      good = (v == 7);
      if (j % 4 == 3) s2 = (v == badVec) ? !good : good;
      else            s2 = !good;
      if (j == 29) start2 = 1'b0;
      if (j % 4 == 0) checkOutput({tag, ".e"}, 32'(e2), 32'(v));
      if (j == 31) begin
        checkOutput({tag, ".busy31"}, 32'(busy2), 1);
        checkOutput({tag, ".done31"}, 32'(done2), 0);
      end
      tick();
    end
    checkOutput({tag, ".done"}, 32'(done2), 1);
    checkOutput({tag, ".err"}, 32'(err2), (badVec < 0) ? 0 : 1);
    checkOutput({tag, ".pass"}, 32'(pass2), (badVec < 0) ? 1 : 0);
    checkOutput({tag, ".failValid"}, 32'(fv2), (badVec < 0) ? 0 : 1);
    if (badVec >= 0) checkOutput({tag, ".failVec"}, 32'(fvec2), 32'(badVec));
  endtask

  initial begin
    rstN   = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    s2     = 1'b0;
    sTable = 8'h80;

    vecs.push_back('{8'h80, 4'd0, 1'b0, 3'd0, 1'b1});
    vecs.push_back('{8'h00, 4'd1, 1'b1, 3'd7, 1'b0});
    vecs.push_back('{8'hFF, 4'd7, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{8'h7F, 4'd8, 1'b1, 3'd0, 1'b0});
    vecs.push_back('{8'h80, 4'd0, 1'b0, 3'd0, 1'b1});
    for (int k = 0; k < 12; k++)
      vecs.push_back(modelSweep(8'($urandom_range(0, 255))));

    tick();
    tick();
    checkOutput("rst.e", 32'(e1), 0);
    checkOutput("rst.busy", 32'(busy1), 0);
    checkOutput("rst.done", 32'(done1), 0);
    checkOutput("rst.pass", 32'(pass1), 0);
    checkOutput("rst.err", 32'(err1), 0);
    checkOutput("rst.failValid", 32'(fv1), 0);
    checkOutput("rst.failVec", 32'(fvec1), 0);
    checkOutput("rst.busy2", 32'(busy2), 0);
    rstN = 1'b1;
    tick();

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], $sformatf("vec%0d", i));

    sTable = 8'hFF;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int j = 0; j < 5; j++) tick();
    checkOutput("midRst.errBefore", 32'(err1), 2);
    rstN = 1'b0;
    tick();
    rstN = 1'b1;
    checkOutput("midRst.e", 32'(e1), 0);
    checkOutput("midRst.busy", 32'(busy1), 0);
    checkOutput("midRst.done", 32'(done1), 0);
    checkOutput("midRst.err", 32'(err1), 0);
    checkOutput("midRst.failValid", 32'(fv1), 0);
    tick();
    applyStimulus('{8'h80, 4'd0, 1'b0, 3'd0, 1'b1}, "afterRst");

    sweepSettle3(-1, "settle3.glitch");
    sweepSettle3(3, "settle3.bad3");

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscomp);
    $finish;
  end

endmodule

// File: doc/and3_exerciser.md
Name: and3_exerciser

Overview:
- Sequential stimulus/response engine for the 3-input AND gate.
- Drives every input combination onto the gate's e1/e2/e3 inputs and samples the gate's output s.
- Compares each sample against the expected AND result, then reports pass/fail, an error count and the first failing vector.
- Sits beside the combinational gate on the board or in the bench, and self-tests the gate after configuration.

Parameters:
- N_IN, 3: number of gate inputs driven; vectors run 0 to 2^N_IN-1.
- SETTLE, 1: extra cycles each vector is held before s is sampled; legal range 0..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- e  out  N_IN  stimulus to the gate; bit 0 is e1, bit 1 is e2, bit 2 is e3.
- s  in  1  gate output being checked.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep end until the next accepted start or reset.
- pass  out  1  valid while done=1; 1 when err_count=0.
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep.
- fail_valid  out  1  at least one mismatch has been recorded.
- fail_vec  out  N_IN  first mismatching vector; valid when fail_valid=1.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge), from any state including mid-sweep:
  - state goes to IDLE;
  - e, busy, done, pass, err_count, fail_valid and fail_vec all go to 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - e=0, busy=0.
  - start=1 at edge T0 moves to RUN. This clears err_count, fail_valid, fail_vec and done, sets vec=0 and the settle counter to 0.
- RUN:
  - busy=1 and e=vec.
  - Each vector is held for exactly SETTLE+1 cycles.
  - The settle counter increments every cycle.
  - On the edge where counter==SETTLE, s is sampled and compared against exp = &vec (1 only when vec is all ones).
  - On mismatch, err_count increments. If fail_valid=0, fail_vec<=vec and fail_valid<=1. Later mismatches never overwrite fail_vec.
  - On that same edge: if vec != 2^N_IN-1, then vec increments and the counter returns to 0; otherwise the block moves to DONE.
- DONE:
  - e=0, busy=0, done=1, pass=(err_count==0).
  - err_count, fail_valid and fail_vec are held.
  - start=1 re-enters RUN with the same clearing as from IDLE, and done drops on that edge.
- Latency:
  - busy rises the cycle after T0.
  - done rises 2^N_IN*(SETTLE+1) cycles after T0; this is 16 cycles for the defaults.
- start while busy=1 is ignored, with no restart and no side effect.
- Mismatch on the final vector is counted before done asserts, so pass reflects every vector.
- err_count width N_IN+1 holds the maximum of 2^N_IN; no saturation logic is needed.
- Arithmetic widths:
  - vec is N_IN bits; there is no wrap-around, because DONE is entered instead.
  - The settle counter is 4 bits.
- s is treated as synchronous to clk; the block has no synchroniser.

Decomposition:
- Shared package and3_pkg:
  - state enum (IDLE, RUN, DONE);
  - the SETTLE_W=4 constant;
  - the function expected_and(vec), which returns &vec.
- No sub-module. Counter, FSM and score logic stay in one module, about 150 lines.

Test Plan:
- Default gate wired to s, start pulse: e steps 0..7 with each vector held 2 cycles. Required: done=1 exactly 16 cycles after T0, pass=1, err_count=0, fail_valid=0.
- s tied to 0: err_count=1, fail_vec=7, fail_valid=1, pass=0.
- s tied to 1: err_count=7, fail_vec=0, pass=0.
- s driven as the inverted gate output: err_count=8, fail_vec=0. Then a second start with the correct gate gives err_count=0 and pass=1, proving the clear on start.
- rst_n low at cycle 5 of a sweep: the next cycle has e=0, busy=0, done=0, err_count=0. A new start then completes normally.
- start held high during RUN, plus a SETTLE=3 build: the sweep is not restarted. With SETTLE=3, each vector is held 4 cycles, done arrives 32 cycles after T0, and s is sampled only on the 4th cycle of each vector. A glitch on s in cycles 1-3 does not count.
